uart_tx_arb: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 114 +++++++++++
 tb/tb_uart_tx_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the uart_tx arbiter
package uart_pkg;

  localparam logic [3:0] TAG_PREFIX = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set finder starting at ptr
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  // First pass finds the lowest set bit (the wrap-around answer); the second
  // pass overrides it with the lowest set bit at or above ptr, if one exists.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_id = ID_W'(i);
        any    = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        gnt_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin frame-locking arbiter feeding one uart_tx stream
// Define UART_TX_ARB_TAG_EN to prefix every frame with a source-ID tag byte.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  arb_state_t            state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;
  logic                  slot_free;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (s_axis_tvalid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign slot_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    sel_data      = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data         = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        s_axis_tready[i] = (state == XFER) && slot_free;
      end
    end
  end

  assign hs = sel_valid && (state == XFER) && slot_free;

`ifdef UART_TX_ARB_TAG_EN
  logic [DATA_WIDTH-1:0] tag_byte;
  assign tag_byte = DATA_WIDTH'({TAG_PREFIX, 1'b0, 3'(grant_id)});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      grant_valid   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      // Drain first; a load further down in the same cycle takes priority.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
            state       <= TAG;
`else
            state       <= XFER;
`endif
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        TAG: begin
          if (slot_free) begin
            m_axis_tdata  <= tag_byte;
            m_axis_tvalid <= 1'b1;
            state         <= XFER;
          end
        end
`endif
        XFER: begin
          if (hs) begin
            m_axis_tdata  <= sel_data;
            m_axis_tvalid <= 1'b1;
            if (sel_last) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              rr_ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef UART_TX_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int checks   = 0;
  int failures = 0;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  uart_tx_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[i]         = v;
    s_tlast[i]          = l;
    s_tdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] tag_of(input int r);
    return {4'hA, 1'b0, 3'(r)};
  endfunction

  // Whole-frame round robin over the pending frame lists, starting at ptr 0.
  function automatic void build_expected();
    logic [8:0] cp [N][$];
    logic [8:0] e;
    int ptr = 0;
    int found;
    exp_q.delete();
    for (int i = 0; i < N; i++) cp[i] = src_q[i];
    forever begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        if (found < 0 && cp[(ptr + k) % N].size() > 0) found = (ptr + k) % N;
      end
      if (found < 0) break;
      if (TAG_ON) exp_q.push_back(tag_of(found));
      do begin
        e = cp[found].pop_front();
        exp_q.push_back(e[7:0]);
      end while (!e[8]);
      ptr = (found + 1) % N;
    end
  endfunction

  task automatic run_engine(input string name, input int stall_at);
    bit first [N];
    bit held  [N];
    logic [8:0] e;
    int cyc = 0;
    build_expected();
    got_q.delete();
    for (int i = 0; i < N; i++) begin
      first[i] = 1'b1;
      held[i]  = 1'b0;
    end
    while (got_q.size() < exp_q.size() && cyc < 5000) begin
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          if (src_q[i].size() > 0 && (first[i] || $urandom_range(3) != 0)) begin
            held[i] = 1'b1;
            set_req(i, 1'b1, src_q[i][0][7:0], src_q[i][0][8]);
          end else begin
            set_req(i, 1'b0, 8'($urandom), 1'b0);
          end
        end
      end
      m_tready = (cyc >= stall_at && cyc < stall_at + 20) ? 1'b0 : ($urandom_range(3) != 0);
      @(negedge clk);
      check({name, "_onehot"}, 32'($countones(s_tready) <= 1), 32'd1);
      if (m_tvalid && !m_tready) check({name, "_backpr"}, 32'(s_tready), 32'd0);
      if (m_tvalid && m_tready) got_q.push_back(m_tdata);
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          e        = src_q[i].pop_front();
          held[i]  = 1'b0;
          first[i] = e[8];
        end
      end
      step();
      cyc++;
    end
    s_tvalid = '0;
    m_tready = 1'b0;
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("%s_byte%0d", name, k), 32'(got_q[k]), 32'(exp_q[k]));
    end
  endtask

  task automatic frame_direct(input int r, input logic [7:0] d [$]);
    do_reset();
    set_req(r, 1'b1, d[0], d.size() == 1);
    m_tready = 1'b1;
    step();
    check("dir_gvalid", 32'(grant_valid), 32'd1);
    check("dir_gid", 32'(grant_id), 32'(r));
    if (TAG_ON) begin
      check("dir_tag_rdy", 32'(s_tready), 32'd0);
      step();
      check("dir_tag_vld", 32'(m_tvalid), 32'd1);
      check("dir_tag_dat", 32'(m_tdata), 32'(tag_of(r)));
    end
    for (int k = 0; k < d.size(); k++) begin
      check("dir_rdy", 32'(s_tready), 32'd1 << r);
      step();
      if (k + 1 < d.size()) set_req(r, 1'b1, d[k+1], (k + 2) == d.size());
      else                  set_req(r, 1'b0, 8'h00, 1'b0);
      check("dir_m_vld", 32'(m_tvalid), 32'd1);
      check("dir_m_dat", 32'(m_tdata), 32'(d[k]));
    end
    check("dir_gdrop", 32'(grant_valid), 32'd0);
    check("dir_rrptr", 32'(dut.rr_ptr), 32'((r + 1) % N));
    step();
    check("dir_drained", 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    int seen;
    int nf;
    int len;
    rst_n    = 1'b0;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = '0;
    m_tready = 1'b1;
    step();
    step();
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_mvalid", 32'(m_tvalid), 32'd0);
    check("rst_mdata", 32'(m_tdata), 32'd0);
    check("rst_gvalid", 32'(grant_valid), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_gvalid", 32'(grant_valid), 32'd1);
    check("rel_gid", 32'(grant_id), 32'd0);

    frame_direct(1, '{8'h48, 8'h69});
    frame_direct(2, '{8'h31});

    // Two requesters, two 3-byte frames each: 0,3,0,3 without interleave.
    do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) begin
        src_q[0].push_back({b == 2, 8'(8'h10 + f * 8'h10 + b)});
        src_q[3].push_back({b == 2, 8'(8'h80 + f * 8'h10 + b)});
      end
    end
    run_engine("pair", 1000);

    do_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    for (int b = 0; b < 5; b++) begin
      src_q[1].push_back({b == 4, 8'($urandom)});
      src_q[2].push_back({b == 4, 8'($urandom)});
    end
    run_engine("stall", 4);

    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        src_q[i].delete();
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      run_engine($sformatf("rand%0d", it), $urandom_range(0, 30));
    end

    // Asynchronous reset while 0x55 sits in the slot under backpressure.
    do_reset();
    set_req(0, 1'b1, 8'h55, 1'b1);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      m_tready = (m_tvalid && m_tdata != 8'h55);
      step();
      if (m_tvalid && m_tdata == 8'h55) begin
        seen = 1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        m_tready = 1'b0;
      end
    end
    check("slot_55", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mvalid", 32'(m_tvalid), 32'd0);
    check("async_gvalid", 32'(grant_valid), 32'd0);
    step();
    rst_n    = 1'b1;
    m_tready = 1'b1;
    seen     = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (m_tvalid) seen++;
    end
    check("no_reemit", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
